// File: rtl/rf_pkg.sv
// Shared register-file constants: widths, arbiter state encodings, write payload.
package rf_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    // Arbiter states; kept as plain constants so older consumers can compare raw bits.
    localparam logic [0:0] ST_PRIO0  = 1'b0;
    localparam logic [0:0] ST_FORCE1 = 1'b1;

    // One write request as presented by either requester.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wrReq_t;

    // Register x0 is hardwired to zero and must never be written.
    function automatic logic isWritableRd(input logic [AW-1:0] rd);
        return rd != AW'(0);
    endfunction

endpackage

// File: rtl/rd_onehot_dec.sv
// Register index to one-hot WriteEn decoder; x0 never decodes to an enable.
module rd_onehot_dec
    import rf_pkg::*;
(
    input  logic [AW-1:0]   rdIdx,
    output logic [NREG-1:0] oneHot_c
);

    // Bit i is set only for rdIdx == i, with i starting at 1 so x0 stays dark.
    always_comb begin
        oneHot_c = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            oneHot_c[i] = (rdIdx == AW'(i));
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-port arbiter for the single register-file write port.
// Port 0 (write-back) has fixed priority; port 1 (long-latency) is force-granted
// after STARVE_MAX consecutive blocked cycles, stalling port 0 for that cycle.
// The accepted write is presented one cycle later on reg_we/reg_wdata.
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            p0_valid,
    output logic            p0_ready,
    input  logic [AW-1:0]   p0_rd,
    input  logic [XLEN-1:0] p0_data,

    input  logic            p1_valid,
    output logic            p1_ready,
    input  logic [AW-1:0]   p1_rd,
    input  logic [XLEN-1:0] p1_data,

    output logic [NREG-1:0] reg_we,
    output logic [XLEN-1:0] reg_wdata,
    output logic            wr_valid,
    output logic [AW-1:0]   wr_rd
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

    logic [0:0]      state;
    logic [0:0]      nextState;
    logic [CW-1:0]   starveCnt;

    logic            acc0;
    logic            acc1;
    logic            anyAcc;
    wrReq_t          req0;
    wrReq_t          req1;
    wrReq_t          selReq;
    logic [NREG-1:0] decOneHot;
    logic [NREG-1:0] weNext;
    logic            writeNext;

    assign req0 = '{rd: p0_rd, data: p0_data};
    assign req1 = '{rd: p1_rd, data: p1_data};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_PRIO0;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and ready generation; a forced grant lasts exactly one cycle.
    always_comb begin
        nextState = state;
        p0_ready  = 1'b1;
        p1_ready  = 1'b0;
        case (state)
            ST_PRIO0: begin
                p1_ready = !p0_valid;
                if (p1_valid && p0_valid && (starveCnt == CNT_LAST)) begin
                    nextState = ST_FORCE1;
                end
            end
            ST_FORCE1: begin
                p0_ready  = 1'b0;
                p1_ready  = 1'b1;
                nextState = ST_PRIO0;
            end
            default: begin
                nextState = ST_PRIO0;
            end
        endcase
    end

    // Accept qualification and selection of the winning request.
    always_comb begin
        acc0      = p0_valid & p0_ready;
        acc1      = p1_valid & p1_ready;
        anyAcc    = acc0 | acc1;
        selReq    = acc1 ? req1 : req0;
        weNext    = anyAcc ? decOneHot : '0;
        writeNext = anyAcc & isWritableRd(selReq.rd);
    end

    rd_onehot_dec uDec (
        .rdIdx    (selReq.rd),
        .oneHot_c (decOneHot)
    );

    // Consecutive blocked cycles of port 1; cleared when it is served or goes idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= '0;
        end else if (!p1_valid || acc1) begin
            starveCnt <= '0;
        end else if (starveCnt != CNT_MAX) begin
            starveCnt <= starveCnt + CW'(1);
        end
    end

    // Write presentation register: enables pulse for one cycle, data/tag hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_we    <= '0;
            reg_wdata <= '0;
            wr_valid  <= 1'b0;
            wr_rd     <= '0;
        end else begin
            reg_we   <= weNext;
            wr_valid <= writeNext;
            if (anyAcc) begin
                reg_wdata <= selReq.data;
                wr_rd     <= selReq.rd;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural arbitration model.
module tb_regfile_wr_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk;
    logic        reset;
    logic        p0_valid;
    logic        p0_ready;
    logic [4:0]  p0_rd;
    logic [31:0] p0_data;
    logic        p1_valid;
    logic        p1_ready;
    logic [4:0]  p1_rd;
    logic [31:0] p1_data;
    logic [31:0] reg_we;
    logic [31:0] reg_wdata;
    logic        wr_valid;
    logic [4:0]  wr_rd;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_rd     (p0_rd),
        .p0_data   (p0_data),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_rd     (p1_rd),
        .p1_data   (p1_data),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .wr_valid  (wr_valid),
        .wr_rd     (wr_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: port 1 gets a forced slot once it has been left waiting
    // STARVE_MAX cycles in a row; a write appears one cycle after its accept.
    int          blockedRun = 0;
    bit          pendValid  = 0;
    logic [4:0]  pendRd     = '0;
    logic [31:0] pendData   = '0;

    always @(negedge clk) begin
        bit          forced;
        bit          e0;
        bit          e1;
        bit          a0;
        bit          a1;
        logic [31:0] expWe;
        if (!reset) begin
            check("m_rst_p0_ready", 32'(p0_ready), 32'd1);
            check("m_rst_p1_ready", 32'(p1_ready), 32'(!p0_valid));
            check("m_rst_reg_we", reg_we, 32'd0);
            check("m_rst_wr_valid", 32'(wr_valid), 32'd0);
            check("m_rst_reg_wdata", reg_wdata, 32'd0);
            check("m_rst_wr_rd", 32'(wr_rd), 32'd0);
            blockedRun = 0;
            pendValid  = 0;
        end else begin
            forced = (blockedRun >= STARVE_MAX);
            e0     = !forced;
            e1     = forced || !p0_valid;
            check("m_p0_ready", 32'(p0_ready), 32'(e0));
            check("m_p1_ready", 32'(p1_ready), 32'(e1));
            expWe = pendValid ? (32'd1 << pendRd) : 32'd0;
            check("m_reg_we", reg_we, expWe);
            check("m_wr_valid", 32'(wr_valid), 32'(pendValid));
            if (pendValid) begin
                check("m_reg_wdata", reg_wdata, pendData);
                check("m_wr_rd", 32'(wr_rd), 32'(pendRd));
            end
            a0 = p0_valid && e0;
            a1 = p1_valid && e1;
            if (a1) begin
                pendValid = (p1_rd != 5'd0);
                pendRd    = p1_rd;
                pendData  = p1_data;
            end else if (a0) begin
                pendValid = (p0_rd != 5'd0);
                pendRd    = p0_rd;
                pendData  = p0_data;
            end else begin
                pendValid = 0;
            end
            blockedRun = (p1_valid && !a1) ? blockedRun + 1 : 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Heavy p0 traffic against a held p1 request; optionally reset during the forced cycle.
    task automatic scenarioStarve(input bit withReset);
        logic [4:0] rd;
        bit         done;
        rd    = 5'd3;
        done  = 0;
        p1_rd   = 5'd7;
        p1_data = 32'hA5A5_A5A5;
        for (int c = 0; c < 8 && !done; c++) begin
            p0_valid = 1'b1;
            p0_rd    = rd;
            p0_data  = 32'h0000_0100 + 32'(rd);
            p1_valid = (c <= 4);
            if (withReset && c == 4) begin
                reset = 1'b0;
                #1;
                check("rst_reg_we", reg_we, 32'd0);
                check("rst_wr_valid", 32'(wr_valid), 32'd0);
                check("rst_p0_ready", 32'(p0_ready), 32'd1);
                check("rst_p1_ready", 32'(p1_ready), 32'd0);
                done = 1;
            end else begin
                #1;
                if (c < 4) begin
                    check("s4_p0_ready", 32'(p0_ready), 32'd1);
                    check("s4_p1_ready", 32'(p1_ready), 32'd0);
                end
                if (c == 4) begin
                    check("s4_force_p0_ready", 32'(p0_ready), 32'd0);
                    check("s4_force_p1_ready", 32'(p1_ready), 32'd1);
                end
                if (c >= 1 && c <= 4) check("s4_p0_write", reg_we, 32'd1 << (c + 2));
                if (c == 5) check("s4_p1_write", reg_we, 32'h0000_0080);
                if (c == 5) check("s4_p1_data", reg_wdata, 32'hA5A5_A5A5);
                if (c == 6) check("s4_p0_resume", reg_we, 32'h0000_0080);
                if (c == 7) check("s4_p0_next", reg_we, 32'h0000_0100);
                if (c != 4) rd = rd + 5'd1;
            end
            step();
        end
    endtask

    initial begin
        reset    = 1'b0;
        p0_valid = 1'b0;
        p0_rd    = '0;
        p0_data  = '0;
        p1_valid = 1'b0;
        p1_rd    = '0;
        p1_data  = '0;
        step();
        step();
        reset = 1'b1;
        #1;
        // 1: idle after reset release
        check("t1_reg_we", reg_we, 32'd0);
        check("t1_wr_valid", 32'(wr_valid), 32'd0);
        check("t1_p0_ready", 32'(p0_ready), 32'd1);
        check("t1_p1_ready", 32'(p1_ready), 32'd1);
        step();

        // 2: single p0 write
        p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'hDEAD_BEEF;
        #1;
        check("t2_p0_ready", 32'(p0_ready), 32'd1);
        step();
        p0_valid = 1'b0;
        #1;
        check("t2_reg_we", reg_we, 32'h0000_0020);
        check("t2_reg_wdata", reg_wdata, 32'hDEAD_BEEF);
        check("t2_wr_valid", 32'(wr_valid), 32'd1);
        check("t2_wr_rd", 32'(wr_rd), 32'd5);
        step();
        check("t2_reg_we_clear", reg_we, 32'd0);

        // 3: write to x0 is accepted but suppressed
        p0_valid = 1'b1; p0_rd = 5'd0; p0_data = 32'h0000_1234;
        #1;
        check("t3_p0_ready", 32'(p0_ready), 32'd1);
        step();
        p0_valid = 1'b0;
        #1;
        check("t3_reg_we", reg_we, 32'd0);
        check("t3_wr_valid", 32'(wr_valid), 32'd0);
        step();

        // 4: starvation forces a p1 grant
        scenarioStarve(1'b0);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        step();

        // 5: p1 alone is accepted immediately
        p1_valid = 1'b1; p1_rd = 5'd31; p1_data = 32'd1;
        #1;
        check("t5_p1_ready", 32'(p1_ready), 32'd1);
        step();
        p1_valid = 1'b0;
        #1;
        check("t5_reg_we", reg_we, 32'h8000_0000);
        check("t5_reg_wdata", reg_wdata, 32'd1);
        check("t5_wr_rd", 32'(wr_rd), 32'd31);
        step();

        // 6: reset during the forced cycle, then starvation restarts from zero;
        // p1 withdraws during its forced slot
        scenarioStarve(1'b1);
        reset    = 1'b1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        #1;
        check("t6_rel_reg_we", reg_we, 32'd0);
        check("t6_rel_p1_ready", 32'(p1_ready), 32'd1);
        step();
        begin
            logic [4:0] rdv;
            rdv = 5'd12;
            for (int c = 0; c < 7; c++) begin
                p0_valid = 1'b1;
                p0_rd    = rdv;
                p0_data  = 32'hC000_0000 | 32'(rdv);
                p1_valid = (c < 4);
                p1_rd    = 5'd9;
                p1_data  = 32'h0000_9999;
                #1;
                if (c < 4) check("t6_p1_blocked", 32'(p1_ready), 32'd0);
                if (c == 4) begin
                    check("t6_force_p0_ready", 32'(p0_ready), 32'd0);
                    check("t6_force_p1_ready", 32'(p1_ready), 32'd1);
                end
                if (c >= 1 && c <= 4) check("t6_p0_write", reg_we, 32'd1 << (c + 11));
                if (c == 5) begin
                    check("t6_back_p0_ready", 32'(p0_ready), 32'd1);
                    check("t6_empty_slot", reg_we, 32'd0);
                end
                if (c == 6) check("t6_p0_resume", reg_we, 32'h0001_0000);
                if (c != 4) rdv = rdv + 5'd1;
                step();
            end
        end

        // Mixed traffic: same rd on both ports, x0 on p1, p0 gaps.
        begin
            logic [4:0] p1r;
            bit         taken;
            p1r = 5'd2;
            p1_valid = 1'b0;
            for (int i = 0; i < 24; i++) begin
                p0_valid = ((i % 4) != 3);
                p0_rd    = 5'(i % 8);
                p0_data  = 32'h5000_0000 + 32'(i);
                if (!p1_valid && (i % 3) != 2) begin
                    p1_valid = 1'b1;
                    p1_rd    = p1r;
                    p1_data  = 32'h6000_0000 + 32'(i);
                end
                #1;
                taken = p1_valid && p1_ready;
                step();
                if (taken) begin
                    p1_valid = 1'b0;
                    p1r      = (p1r == 5'd2) ? 5'd0 : ((p1r == 5'd0) ? 5'd6 : 5'd2);
                end
            end
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
